// File: rtl/exhaustive_tester.sv
`default_nettype none
// ============================================================================
// Module  : exhaustive_tester
// Brief   : Steps an N_IN-bit vector through every combination, samples the
//           function outputs after a settle time and checks them against a
//           programmable expected table; reports pass, error count, 1st fail.
// Rev     : 1.0  initial release
// ============================================================================
module exhaustive_tester #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 5,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  fail_addr,
    output logic [N_OUT-1:0] fail_bits
);

    localparam int c_ROWS  = 2**N_IN;
    localparam int c_CNT_W = $clog2(SETTLE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [N_IN-1:0]    r_vec;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N_OUT-1:0]   r_exp [c_ROWS];
    logic [N_IN:0]      r_err_count;
    logic               r_pass;
    logic               r_fail_valid;
    logic [N_IN-1:0]    r_fail_addr;
    logic [N_OUT-1:0]   r_fail_bits;
    logic [N_OUT-1:0]   w_xor;
    logic               w_mis;
    logic               w_settled;
    logic               w_busy;

    assign w_busy    = (r_state == S_APPLY) || (r_state == S_SAMPLE);
    assign w_settled = (r_cnt == c_CNT_W'(SETTLE - 1));
    assign w_xor     = dut_out ^ r_exp[r_vec];
    assign w_mis     = |w_xor;

    // Table is cleared by reset as well, so a fresh run with no load expects 0s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_ROWS; i++) begin
                r_exp[i] <= '0;
            end
        end else if (cfg_we && !w_busy) begin
            r_exp[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_APPLY;
            S_APPLY:  if (w_settled) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = (&r_vec) ? S_DONE : S_APPLY;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_bits  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_cnt        <= '0;
                        r_err_count  <= '0;
                        r_pass       <= 1'b0;
                        r_fail_valid <= 1'b0;
                        r_fail_addr  <= '0;
                        r_fail_bits  <= '0;
                    end
                end
                S_APPLY: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_SAMPLE: begin
                    if (w_mis) begin
                        r_err_count <= r_err_count + (N_IN+1)'(1);
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_addr  <= r_vec;
                            r_fail_bits  <= w_xor;
                        end
                    end
                    // The last vector stays on dut_in after the run ends.
                    if (!(&r_vec)) begin
                        r_vec <= r_vec + N_IN'(1);
                        r_cnt <= '0;
                    end
                end
                S_DONE: begin
                    r_pass <= (r_err_count == '0);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign dut_in     = r_vec;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign fail_addr  = r_fail_addr;
    assign fail_bits  = r_fail_bits;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_tester.sv
`default_nettype none
// ============================================================================
// Module  : tb_exhaustive_tester
// Brief   : Scoreboard bench for exhaustive_tester: stimulus pushes expected
//           run results, a monitor pops and compares them on each done pulse.
// Rev     : 1.0  initial release
// ============================================================================
module tb_exhaustive_tester;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [4:0] cfg_data = '0;
    logic [3:0] dut_in;
    logic [4:0] dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_addr;
    logic [4:0] fail_bits;

    typedef struct {
        int         done_cyc;
        logic       pass;
        logic [4:0] err;
        logic       fv;
        logic [3:0] fa;
        logic [4:0] fb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   mode   = 0;       // 0: outputs tied low, 1: true function, 2: inverted
    logic pend_pass = 1'b0;
    logic pend_val  = 1'b0;

    exhaustive_tester #(.N_IN(4), .N_OUT(5), .SETTLE(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .fail_bits  (fail_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] f_model(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {a & b, a | c, b ^ d, ~(a & c), a ^ b ^ c ^ d};
    endfunction

    always_comb begin
        dut_out = 5'd0;
        if (mode == 1)      dut_out = f_model(dut_in);
        else if (mode == 2) dut_out = ~f_model(dut_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pass updates on the edge leaving DONE, so it is checked one cycle later.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("err_count", err_count, e.err);
                chk("fail_valid", fail_valid, e.fv);
                chk("fail_addr", fail_addr, e.fa);
                chk("fail_bits", fail_bits, e.fb);
                pend_val  = e.pass;
                pend_pass = 1'b1;
            end
        end else if (pend_pass) begin
            chk("pass", pass, pend_val);
            pend_pass = 1'b0;
        end
    end

    task automatic load_table(input logic [3:0] fa0, input logic [4:0] fm0,
                              input logic [3:0] fa1, input logic [4:0] fm1);
        for (int v = 0; v < 16; v++) begin
            logic [4:0] row;
            row = f_model(4'(v));
            if (4'(v) == fa0) row = row ^ fm0;
            if (4'(v) == fa1) row = row ^ fm1;
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 4'(v);
            cfg_data = row;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push(input int dcyc, input logic p, input logic [4:0] err,
                        input logic fv, input logic [3:0] fa, input logic [4:0] fb);
        exp_t e;
        e.done_cyc = dcyc; e.pass = p; e.err = err; e.fv = fv; e.fa = fa; e.fb = fb;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || pend_pass) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || pend_pass) begin
            chk("timeout_done", 32'd0, 32'd1);
            sb.delete();
            pend_pass = 1'b0;
        end
    endtask

    // Issues start, checks busy/dut_in per cycle; poke drives start/cfg_we mid-run.
    task automatic run(input logic p, input logic [4:0] err, input logic fv,
                       input logic [3:0] fa, input logic [4:0] fb, input bit poke);
        @(negedge clk);
        start = 1'b1;
        push(cyc + 49, p, err, fv, fa, fb);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i % 3 == 0) begin
                chk("busy_run", busy, 1'b1);
                chk("dut_in_step", dut_in, 32'(i / 3));
            end
            if (done) chk("early_done", done, 1'b0);
            if (poke && (i == 10 || i == 25)) begin
                start    = 1'b1;
                cfg_we   = 1'b1;
                cfg_addr = 4'd3;
                cfg_data = ~f_model(4'd3);
            end else begin
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        chk("busy_in_done", busy, 1'b0);
        wait_drain();
        chk("dut_in_hold", dut_in, 4'hF);
    endtask

    initial begin
        reset = 1'b1;
        #23;
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fv", fail_valid, 0);
        chk("rst_fa", fail_addr, 0);
        chk("rst_fb", fail_bits, 0);
        @(negedge clk);
        reset = 1'b0;

        // Empty table, outputs low
        mode = 0;
        run(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0);

        // Matching run
        mode = 1;
        load_table(4'd0, 5'd0, 4'd0, 5'd0);
        run(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0);

        // Two faults in the table
        load_table(4'd9, 5'b00100, 4'd14, 5'b00001);
        run(1'b0, 5'd2, 1'b1, 4'd9, 5'b00100, 1'b0);

        // Everything wrong
        load_table(4'd0, 5'd0, 4'd0, 5'd0);
        mode = 2;
        run(1'b0, 5'b10000, 1'b1, 4'd0, 5'b11111, 1'b0);

        // Start and cfg writes ignored while busy; next run must still pass
        mode = 1;
        run(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1);
        run(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0);

        // Reset at vector 7
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        chk("pre_rst_vec", dut_in, 4'd7);
        reset = 1'b1;
        #1;
        chk("mid_rst_dut_in", dut_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) chk("post_rst_idle", {done, busy}, 2'b00);
        end
        chk("post_rst_busy", busy, 0);
        load_table(4'd0, 5'd0, 4'd0, 5'd0);
        run(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/exhaustive_tester.md
# exhaustive_tester

Hardware truth-table sequencer for the experiment's small combinational function blocks (4-input functions, several outputs). It steps an N_IN-bit input vector through all 2^N_IN combinations in binary order. At each vector it waits a programmable settle time, samples the function outputs and compares them against an internally stored expected table. It replaces the hand-written delay stimulus with a self-checking, clocked controller that reports pass/fail, the error count and the first failing vector.

## Interface
- N_IN, 4: number of function inputs; vector bit N_IN-1 drives A, bit 0 drives the last input.
- N_OUT, 5: number of function outputs checked in parallel.
- SETTLE, 2: cycles each vector is held before sampling; legal range ≥1.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE
- cfg_we  in  1  write one expected-table row; honoured only when busy=0
- cfg_addr  in  N_IN  row (input vector) being written
- cfg_data  in  N_OUT  expected outputs for that row
- dut_in  out  N_IN  vector driven to the functions under test
- dut_out  in  N_OUT  outputs of the functions under test
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last completed run had zero mismatches
- err_count  out  N_IN+1  mismatching vectors in the current or last run
- fail_valid  out  1  a first failure has been captured
- fail_addr  out  N_IN  vector of the first mismatch
- fail_bits  out  N_OUT  dut_out XOR expected at the first mismatch

## Operation
- Expected table: 2^N_IN × N_OUT register array. It is written on the clock edge when cfg_we=1 and busy=0. Writes with busy=1 are dropped.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE→APPLY on start=1. At that transition: vec←0, settle counter←0, err_count←0, fail_valid←0, fail_addr←0, fail_bits←0, pass←0.
- APPLY: dut_in=vec. The settle counter increments each cycle. When the counter reaches SETTLE-1, the FSM moves to SAMPLE, so APPLY lasts exactly SETTLE cycles.
- SAMPLE, lasting 1 cycle:
  - At the closing edge, compare dut_out with exp[vec].
  - On mismatch, err_count increments. If fail_valid=0, capture fail_addr=vec and fail_bits=XOR, and set fail_valid=1.
  - If vec is all-ones, go to DONE. Otherwise vec increments, the counter resets to 0, and the FSM returns to APPLY.
- DONE, lasting 1 cycle: done=1. pass is set to 1 if err_count==0, otherwise 0. The FSM then goes to IDLE.
- start is ignored in APPLY, SAMPLE and DONE; it is not queued.
- Results (pass, err_count, fail_*) hold until the next accepted start.
- err_count saturation is not needed: the width N_IN+1 holds the maximum of 2^N_IN.
- cfg_we and start in the same IDLE cycle: both take effect. The write lands before any compare.

## Timing
- Reset values: state IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_addr=0, fail_bits=0, and all expected-table rows 0.
- busy=1 exactly while in APPLY or SAMPLE.
- Each vector lasts SETTLE+1 cycles. dut_in changes on the edge entering APPLY and is stable through SAMPLE. dut_out is sampled on the edge leaving SAMPLE.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k + 2^N_IN·(SETTLE+1). With the defaults this is edge k+48, a 49-cycle run including DONE.
- In the final state of a run, dut_in holds the all-ones vector through DONE and IDLE until the next start.
- Reset mid-run: all outputs return immediately (asynchronously) to their reset values. No done pulse is issued. The expected table is cleared and must be reloaded.

## Test plan
- Reset: assert reset, then release → all outputs 0, busy=0. A subsequent run with no table loaded and dut_out tied to 0 gives pass=1, err_count=0.
- Matching run: load exp[v] = {A&B, A|C, B^D, ~(A&C), A^B^C^D}; the bench models the same function. Pulse start → busy for 48 cycles, done at edge +48, pass=1, err_count=0, fail_valid=0. dut_in steps 0..15, each vector held 3 cycles.
- Two faults: flip bit 2 of exp[9] and bit 0 of exp[14] → err_count=2, pass=0, fail_valid=1, fail_addr=9, fail_bits=5'b00100.
- All-fail: the model returns ~expected on all 5 bits → err_count=16 (5'b10000), fail_addr=0, fail_bits=5'b11111.
- Ignore while busy: start pulses and cfg_we to addr 3 during the run → no restart and done still at +48. The table is unchanged, so the next run passes.
- Reset mid-run: assert reset at vector 7 → dut_in=0, busy=0, no done. Reload the table and start → a full 48-cycle run that passes.
